// File: rtl/match_filter_tdm.sv
// Time-division complex matched filter: correlates the RX stream against a
// programmable QPSK-sign tap sequence, LANES taps per clock, then thresholds.
module match_filter_tdm #(
  parameter int DW     = 16,
  parameter int MAXLEN = 256,
  parameter int LANES  = 64,
  localparam int ACCW  = DW + $clog2(MAXLEN) + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] rx_i,
  input  logic signed [DW-1:0] rx_q,
  input  logic                 rxstrobe,
  input  logic [31:0]          cdata,
  input  logic [5:0]           caddr,
  input  logic                 cwrite,
  output logic                 valid,
  output logic                 match,
  output logic [ACCW-1:0]      mag,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          debugbus
);
  localparam int TAPW  = $clog2(MAXLEN);
  localparam int LENW  = TAPW + 1;
  localparam int NWORD = MAXLEN / 16;
  localparam int PASSW = $clog2(MAXLEN / LANES + 1);
  localparam int LSH   = $clog2(LANES);
  localparam int LW    = DW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // rxstrobe and valid are single-cycle qualifiers with no back-pressure: a
  // strobe is consumed on the clock it is high, valid is high for one clock.
  state_t state_q, state_d;
  logic [PASSW-1:0] pass_q, pass_d;
  logic [1:0] drain_q, drain_d;
  logic res_v;

  logic [LENW-1:0] len_q;
  logic [ACCW-1:0] thr_q;
  logic [15:0] holdoff_q, hold_cnt_q;
  logic cfg_ok_q, overrun_q, hz_q;
  logic [2*MAXLEN-1:0] coef_q;
  logic signed [DW-1:0] dl_i_q [MAXLEN];
  logic signed [DW-1:0] dl_q_q [MAXLEN];

  logic wr_len, wr_thr, wr_hold, wr_ctl, wr_coef, cfg_kill, start, hit;
  logic [LENW-1:0] len_d;
  logic [LENW:0] len_rnd;
  logic [PASSW-1:0] last_pass;

  logic signed [LW-1:0] lre_d [LANES];
  logic signed [LW-1:0] lim_d [LANES];
  logic signed [LW-1:0] lre_q [LANES];
  logic signed [LW-1:0] lim_q [LANES];
  logic s1_v_q, s1_first_q, s2_v_q, s2_first_q;
  logic signed [ACCW-1:0] tre_d, tim_d, tre_q, tim_q, acc_re_q, acc_im_q;
  logic [ACCW-1:0] are, aim, mx, mn, magc_d, magc_q;
  logic [ACCW:0] msum;
  logic valid_q, match_q;
  logic [ACCW-1:0] mag_q;

  assign wr_len   = cwrite && (caddr == 6'd0);
  assign wr_thr   = cwrite && (caddr == 6'd1);
  assign wr_hold  = cwrite && (caddr == 6'd2);
  assign wr_ctl   = cwrite && (caddr == 6'd3);
  assign wr_coef  = cwrite && caddr[5];
  assign cfg_kill = wr_len || wr_coef || (wr_ctl && !cdata[0]);
  assign start    = (state_q == S_IDLE) && rxstrobe && cfg_ok_q && !cfg_kill;

  always_comb begin
    if (cdata == 32'd0)              len_d = LENW'(1);
    else if (cdata > 32'(MAXLEN))    len_d = LENW'(MAXLEN);
    else                             len_d = cdata[LENW-1:0];
  end

  assign len_rnd   = {1'b0, len_q} + (LENW+1)'(LANES - 1);
  assign last_pass = PASSW'(len_rnd >> LSH) - PASSW'(1);

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    res_v   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        pass_d  = '0;
      end
      S_RUN: if (pass_q == last_pass) begin
        state_d = S_DRAIN;
        drain_d = '0;
      end else begin
        pass_d = pass_q + PASSW'(1);
      end
      S_DRAIN: if (drain_q == 2'd3) begin
        state_d = S_IDLE;
        res_v   = 1'b1;
      end else begin
        drain_d = drain_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // A strobe or a configuration kill while busy abandons the result.
    if (state_q != S_IDLE && (rxstrobe || cfg_kill)) begin
      state_d = S_IDLE;
      res_v   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= LENW'(MAXLEN);
      thr_q     <= '1;
      holdoff_q <= '0;
      cfg_ok_q  <= 1'b0;
      coef_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < MAXLEN; k++) begin
        dl_i_q[k] <= '0;
        dl_q_q[k] <= '0;
      end
    end else begin
      if (wr_len)  len_q     <= len_d;
      if (wr_thr)  thr_q     <= ACCW'(cdata);
      if (wr_hold) holdoff_q <= cdata[15:0];
      if (wr_len || wr_coef) cfg_ok_q <= 1'b0;
      else if (wr_ctl)       cfg_ok_q <= cdata[0];
      for (int w = 0; w < NWORD; w++)
        if (wr_coef && caddr[4:0] == 5'(w)) coef_q[w*32 +: 32] <= cdata;
      if (busy && rxstrobe)          overrun_q <= 1'b1;
      else if (wr_ctl && cdata[1])   overrun_q <= 1'b0;
      if (rxstrobe) begin
        dl_i_q[0] <= rx_i;
        dl_q_q[0] <= rx_q;
        for (int k = 1; k < MAXLEN; k++) begin
          dl_i_q[k] <= dl_i_q[k-1];
          dl_q_q[k] <= dl_q_q[k-1];
        end
      end
    end
  end

  // Each lane multiplies one sample by conj(c); operands widened before negation.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [TAPW-1:0] idx;
    logic on, cr, ci;
    logic signed [LW-1:0] a, b;
    assign idx = TAPW'(pass_q) * TAPW'(LANES) + TAPW'(l);
    assign on  = ({1'b0, idx} < len_q);
    assign cr  = coef_q[{idx, 1'b1}];
    assign ci  = coef_q[{idx, 1'b0}];
    assign a   = LW'(dl_i_q[idx]);
    assign b   = LW'(dl_q_q[idx]);
    assign lre_d[l] = on ? ((cr ? -a : a) + (ci ? -b : b)) : '0;
    assign lim_d[l] = on ? ((cr ? -b : b) + (ci ? a : -a)) : '0;
  end

  always_comb begin
    tre_d = '0;
    tim_d = '0;
    for (int l = 0; l < LANES; l++) begin
      tre_d = tre_d + ACCW'(lre_q[l]);
      tim_d = tim_d + ACCW'(lim_q[l]);
    end
  end

  always_comb begin
    are    = acc_re_q[ACCW-1] ? -acc_re_q : acc_re_q;
    aim    = acc_im_q[ACCW-1] ? -acc_im_q : acc_im_q;
    mx     = (are > aim) ? are : aim;
    mn     = (are > aim) ? aim : are;
    msum   = {1'b0, mx} + {2'b00, mn[ACCW-1:1]};
    magc_d = msum[ACCW] ? '1 : msum[ACCW-1:0];
  end

  // Holdoff is judged on the count seen when the correlated sample arrived.
  assign hit = (magc_q > thr_q) && hz_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        lre_q[l] <= '0;
        lim_q[l] <= '0;
      end
      s1_v_q <= 1'b0; s1_first_q <= 1'b0;
      s2_v_q <= 1'b0; s2_first_q <= 1'b0;
      tre_q <= '0; tim_q <= '0;
      acc_re_q <= '0; acc_im_q <= '0;
      magc_q <= '0; mag_q <= '0;
      valid_q <= 1'b0; match_q <= 1'b0;
      hold_cnt_q <= '0; hz_q <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        lre_q[l] <= lre_d[l];
        lim_q[l] <= lim_d[l];
      end
      s1_v_q     <= (state_q == S_RUN);
      s1_first_q <= (pass_q == '0);
      s2_v_q     <= s1_v_q;
      s2_first_q <= s1_first_q;
      tre_q      <= tre_d;
      tim_q      <= tim_d;
      if (s2_v_q) begin
        acc_re_q <= s2_first_q ? tre_q : acc_re_q + tre_q;
        acc_im_q <= s2_first_q ? tim_q : acc_im_q + tim_q;
      end
      magc_q  <= magc_d;
      valid_q <= res_v;
      match_q <= res_v && hit;
      if (res_v) mag_q <= magc_q;
      if (start) hz_q <= (hold_cnt_q == '0);
      if (res_v && hit)                       hold_cnt_q <= holdoff_q;
      else if (rxstrobe && hold_cnt_q != '0)  hold_cnt_q <= hold_cnt_q - 16'd1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign valid    = valid_q;
  assign match    = match_q;
  assign mag      = mag_q;
  assign overrun  = overrun_q;
  assign debugbus = {busy, valid_q, match_q, overrun_q, cfg_ok_q, 4'(pass_q),
                     (hold_cnt_q != '0), 6'b0};
endmodule

// File: tb/tb_match_filter_tdm.sv
// Bench for match_filter_tdm: a reference correlator predicts every result,
// which is queued at strobe time and compared when valid appears.
module tb_match_filter_tdm;
  localparam int DW = 16, MAXLEN = 256, LANES = 64;
  localparam int ACCW = DW + $clog2(MAXLEN) + 2;

  logic clk = 1'b0;
  logic reset;
  logic signed [DW-1:0] rx_i, rx_q;
  logic rxstrobe, cwrite;
  logic [31:0] cdata;
  logic [5:0] caddr;
  logic valid, match, busy, overrun;
  logic [ACCW-1:0] mag;
  logic [15:0] debugbus;

  match_filter_tdm #(.DW(DW), .MAXLEN(MAXLEN), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .rx_q(rx_q), .rxstrobe(rxstrobe),
    .cdata(cdata), .caddr(caddr), .cwrite(cwrite), .valid(valid), .match(match),
    .mag(mag), .busy(busy), .overrun(overrun), .debugbus(debugbus)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int m_i [MAXLEN];
  int m_q [MAXLEN];
  bit m_cr [MAXLEN];
  bit m_ci [MAXLEN];
  int m_len, m_holdoff, m_hold;
  longint m_thr;

  logic [ACCW:0] exp_q[$];
  int exp_t_q[$];
  int n_cmp = 0, n_err = 0, n_match_seen = 0;
  logic [ACCW:0] mon_e;
  int mon_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < MAXLEN; k++) begin
      m_i[k] = 0; m_q[k] = 0; m_cr[k] = 0; m_ci[k] = 0;
    end
    m_len = MAXLEN; m_holdoff = 0; m_hold = 0;
    m_thr = (longint'(1) << ACCW) - 1;
  endtask

  function automatic longint model_mag();
    longint re, im, ar, ai, mx, mn, m, sr, si, lim;
    re = 0; im = 0;
    for (int k = 0; k < m_len; k++) begin
      sr = m_cr[k] ? -1 : 1;
      si = m_ci[k] ? -1 : 1;
      re += longint'(m_i[k]) * sr + longint'(m_q[k]) * si;
      im += longint'(m_q[k]) * sr - longint'(m_i[k]) * si;
    end
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    m = mx + mn / 2;
    lim = (longint'(1) << ACCW) - 1;
    if (m > lim) m = lim;
    return m;
  endfunction

  // driver tasks
  task automatic wr(input int addr, input logic [31:0] d);
    int w;
    @(negedge clk);
    caddr = 6'(addr); cdata = d; cwrite = 1'b1;
    @(negedge clk);
    cwrite = 1'b0;
    case (addr)
      0: m_len = (d == 0) ? 1 : ((d > MAXLEN) ? MAXLEN : int'(d));
      1: m_thr = longint'(d[ACCW-1:0]);
      2: m_holdoff = int'(d[15:0]);
      default: ;
    endcase
    if (addr >= 32 && addr < 32 + MAXLEN / 16) begin
      w = addr - 32;
      for (int t = 0; t < 16; t++) begin
        m_cr[16*w+t] = d[2*t+1];
        m_ci[16*w+t] = d[2*t];
      end
    end
  endtask

  task automatic strobe(input int a, input int b, input bit expect_res, input int gap);
    longint m;
    bit blocked, hitm;
    @(negedge clk);
    rx_i = DW'(a); rx_q = DW'(b); rxstrobe = 1'b1;
    for (int k = MAXLEN - 1; k > 0; k--) begin
      m_i[k] = m_i[k-1]; m_q[k] = m_q[k-1];
    end
    m_i[0] = a; m_q[0] = b;
    blocked = (m_hold != 0);
    if (m_hold != 0) m_hold--;
    if (expect_res) begin
      m = model_mag();
      hitm = (m > m_thr) && !blocked;
      if (hitm) m_hold = m_holdoff;
      exp_q.push_back({hitm, ACCW'(m)});
      exp_t_q.push_back(cyc + (m_len + LANES - 1) / LANES + 5);
    end
    @(negedge clk);
    rxstrobe = 1'b0;
    if (expect_res) check("busy_run", busy, 1);
    repeat (gap) @(negedge clk);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!reset && match && !valid) check("match_unqualified", 1, 0);
    if (!reset && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("mag", mag, mon_e[ACCW-1:0]);
        check("match", match, mon_e[ACCW]);
        check("latency", cyc, mon_t);
        check("busy_at_valid", busy, 0);
        if (match) n_match_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_mag"}, mag, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_debugbus"}, debugbus, 0);
  endtask

  initial begin
    reset = 1'b1; rxstrobe = 1'b0; cwrite = 1'b0; cdata = '0; caddr = '0;
    rx_i = '0; rx_q = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // short filter, constant input
    wr(0, 4); wr(1, 500); wr(3, 1);
    for (int s = 0; s < 4; s++) strobe(100, 0, 1, 16);
    check("t1_mag_hand", mag, 600);
    wr(1, 600);
    strobe(100, 0, 1, 16);
    check("t2_mag_hand", mag, 600);

    // full length, alternating coefficient words, impulse at the negative limit
    wr(0, 256);
    for (int w = 0; w < 16; w++) wr(32 + w, (w % 2) ? 32'hFFFF_FFFF : 32'h0);
    for (int s = 0; s < MAXLEN; s++) strobe(0, 0, 0, 0);
    wr(3, 1);
    strobe(-32768, -32768, 1, 12);
    check("imp_tap0_hand", mag, 65536);
    for (int s = 0; s < 17; s++) strobe(0, 0, 1, 12);
    check("imp_tap17_hand", mag, 65536);

    // overrun: second strobe three clocks after the first
    strobe(rnd_s(), rnd_s(), 0, 1);
    strobe(rnd_s(), rnd_s(), 0, 15);
    check("overrun_set", overrun, 1);
    check("overrun_busy", busy, 0);
    wr(3, 3);
    check("overrun_clr", overrun, 0);
    check("cfg_ok_on", debugbus[11], 1);

    // random streams: mid length, length 0 -> 1, length clamp
    wr(0, 100); wr(1, 300000);
    for (int w = 0; w < 16; w++) wr(32 + w, $urandom);
    wr(3, 1);
    for (int s = 0; s < 20; s++) strobe(rnd_s(), rnd_s(), 1, 10);
    wr(0, 0); wr(1, 30000); wr(3, 1);
    for (int s = 0; s < 6; s++) strobe(rnd_s(), rnd_s(), 1, 8);
    wr(0, 1000); wr(1, 500000); wr(3, 1);
    for (int s = 0; s < 6; s++) strobe(rnd_s(), rnd_s(), 1, 12);

    // holdoff with constant matching input
    wr(3, 0); wr(0, 4); wr(32, 0); wr(1, 500);
    for (int s = 0; s < 4; s++) strobe(100, 0, 0, 2);
    wr(2, 3); wr(3, 1);
    n_match_seen = 0;
    for (int s = 0; s < 6; s++) strobe(100, 0, 1, 12);
    check("hold_matches", n_match_seen, 2);

    // coefficient write during RUN aborts silently
    wr(0, 256); wr(3, 1);
    strobe(rnd_s(), rnd_s(), 0, 0);
    wr(40, 32'h1234_5678);
    check("kill_busy", busy, 0);
    check("kill_cfg_ok", debugbus[11], 0);
    check("kill_overrun", overrun, 0);
    repeat (15) @(negedge clk);

    // reset during RUN
    wr(3, 1);
    strobe(rnd_s(), rnd_s(), 0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all_zero("midreset");
    repeat (15) @(negedge clk);

    // recovery after reset
    wr(0, 4); wr(1, 100); wr(3, 1);
    for (int s = 0; s < 5; s++) strobe(rnd_s(), rnd_s(), 1, 10);

    repeat (20) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
